// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared constants and push/pop op decode for the return-address stack
package ras_pkg;

  localparam int RAS_WIDTH = 32;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_CKPT  = 8;

  typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP, OP_REPL} ras_op_e;

  // Push+pop on an empty stack degenerates to a plain push; pop on empty is dropped.
  function automatic ras_op_e ras_decode(input logic push, input logic pop, input logic nonempty);
    if (push && pop && nonempty) return OP_REPL;
    if (push)                    return OP_PUSH;
    if (pop && nonempty)         return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/ras_ckpt_queue.sv
// rtl/ras_ckpt_queue.sv - circular checkpoint store with in-order commit and flush-truncate
module ras_ckpt_queue #(
  parameter int CKPT = 8,
  parameter int PW   = 9,
  localparam int TW  = $clog2(CKPT)
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          commit_i,
  input  logic          flush_i,
  input  logic [TW-1:0] flush_tag_i,
  input  logic [PW-1:0] wdata_i,
  output logic          rdy_o,
  output logic [TW-1:0] tag_o,
  output logic [PW-1:0] rdata_o
);

  logic [PW-1:0] r_slot [CKPT];
  logic [TW-1:0] r_head;
  logic [TW-1:0] r_tail;
  logic [TW:0]   r_live;

  logic          w_rdy;
  logic          w_commit;
  logic          w_alloc;
  logic [TW-1:0] w_head_c;
  logic [TW:0]   w_live_c;
  logic [TW:0]   w_flush_off;

  assign w_rdy       = r_live < (TW+1)'(CKPT);
  assign w_commit    = commit_i && (r_live != '0);
  assign w_alloc     = req_i && w_rdy && !flush_i;
  // Commit retires first, so a same-cycle flush measures its age from the new head.
  assign w_head_c    = r_head + TW'(w_commit);
  assign w_live_c    = r_live - (TW+1)'(w_commit);
  assign w_flush_off = {1'b0, flush_tag_i - w_head_c};

  assign rdy_o   = w_rdy;
  assign tag_o   = r_tail;
  assign rdata_o = r_slot[flush_tag_i];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_live <= '0;
    end else begin
      r_head <= w_head_c;
      if (flush_i) begin
        assert (w_flush_off < w_live_c);
        r_tail <= flush_tag_i;
        r_live <= w_flush_off;
      end else begin
        r_tail <= r_tail + TW'(w_alloc);
        r_live <= r_live + (TW+1)'(w_alloc) - (TW+1)'(w_commit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i && w_alloc) r_slot[r_tail] <= wdata_i;
  end

endmodule

// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - speculative return-address stack with checkpoint recovery
// Optional top-entry data repair on flush: define RAS_TOS_REPAIR_EN.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int WIDTH = RAS_WIDTH,
  parameter int DEPTH = RAS_DEPTH,
  parameter int CKPT  = RAS_CKPT,
  localparam int AW   = $clog2(DEPTH),
  localparam int TW   = $clog2(CKPT)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [AW:0]      count_o,
  input  logic             ckpt_req_i,
  output logic             ckpt_rdy_o,
  output logic [TW-1:0]    ckpt_tag_o,
  input  logic             commit_i,
  input  logic             flush_i,
  input  logic [TW-1:0]    flush_tag_i,
  output logic             ovf_o
);

`ifdef RAS_TOS_REPAIR_EN
  localparam int PW = AW + AW + 1 + WIDTH;
`else
  localparam int PW = AW + AW + 1;
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_tosp;
  logic [AW:0]      r_count;
  logic             r_ovf;

  ras_op_e          w_op;
  logic             w_full;
  logic [AW-1:0]    w_tosp_inc;
  logic [AW-1:0]    w_tosp_dec;
  logic [AW-1:0]    w_nxt_tosp;
  logic [AW:0]      w_nxt_count;
  logic [PW-1:0]    w_ck_wdata;
  logic [PW-1:0]    w_ck_rdata;
  logic [AW-1:0]    w_rs_tosp;
  logic [AW:0]      w_rs_count;

  assign w_op       = ras_decode(push_i, pop_i, r_count != '0);
  assign w_full     = r_count == (AW+1)'(DEPTH);
  assign w_tosp_inc = r_tosp + AW'(1);
  assign w_tosp_dec = r_tosp - AW'(1);

  always_comb begin
    w_nxt_tosp  = r_tosp;
    w_nxt_count = r_count;
    case (w_op)
      OP_PUSH: begin
        w_nxt_tosp  = w_tosp_inc;
        w_nxt_count = w_full ? r_count : r_count + (AW+1)'(1);
      end
      OP_POP: begin
        w_nxt_tosp  = w_tosp_dec;
        w_nxt_count = r_count - (AW+1)'(1);
      end
      default: ;
    endcase
  end

`ifdef RAS_TOS_REPAIR_EN
  logic [WIDTH-1:0] w_nxt_top;
  logic [WIDTH-1:0] w_rs_data;

  // Top data as it will read after this cycle's op, without waiting for the array write.
  always_comb begin
    w_nxt_top = r_mem[r_tosp];
    case (w_op)
      OP_PUSH, OP_REPL: w_nxt_top = din_i;
      OP_POP:           w_nxt_top = r_mem[w_tosp_dec];
      default: ;
    endcase
  end

  assign w_ck_wdata = {w_nxt_tosp, w_nxt_count, w_nxt_top};
  assign w_rs_data  = w_ck_rdata[WIDTH-1:0];
`else
  assign w_ck_wdata = {w_nxt_tosp, w_nxt_count};
`endif

  assign w_rs_tosp  = w_ck_rdata[PW-1 -: AW];
  assign w_rs_count = w_ck_rdata[PW-AW-1 -: AW+1];

  ras_ckpt_queue #(
    .CKPT (CKPT),
    .PW   (PW)
  ) u_ckpt_queue (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (ckpt_req_i),
    .commit_i    (commit_i),
    .flush_i     (flush_i),
    .flush_tag_i (flush_tag_i),
    .wdata_i     (w_ck_wdata),
    .rdy_o       (ckpt_rdy_o),
    .tag_o       (ckpt_tag_o),
    .rdata_o     (w_ck_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_tosp  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (flush_i) begin
      r_tosp  <= w_rs_tosp;
      r_count <= w_rs_count;
      r_ovf   <= 1'b0;
    end else begin
      r_tosp  <= w_nxt_tosp;
      r_count <= w_nxt_count;
      r_ovf   <= (w_op == OP_PUSH) && w_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      if (flush_i) begin
`ifdef RAS_TOS_REPAIR_EN
        r_mem[w_rs_tosp] <= w_rs_data;
`endif
      end else if (w_op == OP_PUSH) begin
        r_mem[w_tosp_inc] <= din_i;
      end else if (w_op == OP_REPL) begin
        r_mem[r_tosp] <= din_i;
      end
    end
  end

  assign dout_o  = r_mem[r_tosp];
  assign valid_o = r_count != '0;
  assign count_o = r_count;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - directed and randomized checks of ras_ckpt against a stack/queue model
module tb_ras_ckpt;

  localparam int W = 32;
  localparam int D = 16;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         push_i = 1'b0;
  logic         pop_i = 1'b0;
  logic [W-1:0] din_i = '0;
  logic [W-1:0] dout_o;
  logic         valid_o;
  logic [4:0]   count_o;
  logic         ckpt_req_i = 1'b0;
  logic         ckpt_rdy_o;
  logic [2:0]   ckpt_tag_o;
  logic         commit_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [2:0]   flush_tag_i = '0;
  logic         ovf_o;

  always #5 clk = ~clk;

  ras_ckpt dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .din_i       (din_i),
    .dout_o      (dout_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .ckpt_req_i  (ckpt_req_i),
    .ckpt_rdy_o  (ckpt_rdy_o),
    .ckpt_tag_o  (ckpt_tag_o),
    .commit_i    (commit_i),
    .flush_i     (flush_i),
    .flush_tag_i (flush_tag_i),
    .ovf_o       (ovf_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: circular array with top index and occupancy, checkpoints as an ordered list.
  typedef struct {
    int           tag;
    int           top;
    int           cnt;
    logic [W-1:0] data;
    bit           known;
  } ck_t;

  logic [W-1:0] m_mem [D];
  bit           m_known [D];
  int           m_top = 0;
  int           m_cnt = 0;
  int           m_tail = 0;
  bit           m_ovf = 0;
  ck_t          m_ck [$];

  task automatic model_step();
    bit can_alloc;
    int idx;
    if (rst_i) begin
      m_top = 0; m_cnt = 0; m_tail = 0; m_ovf = 0;
      m_ck.delete();
      return;
    end
    can_alloc = m_ck.size() < C;
    if (commit_i && m_ck.size() > 0) void'(m_ck.pop_front());
    m_ovf = 0;
    if (flush_i) begin
      idx = -1;
      foreach (m_ck[k]) if (m_ck[k].tag == int'(flush_tag_i)) idx = k;
      if (idx < 0) begin
        chk("flush_tag_live", 0, 1);
        return;
      end
      m_top = m_ck[idx].top;
      m_cnt = m_ck[idx].cnt;
`ifdef RAS_TOS_REPAIR_EN
      m_mem[m_top]   = m_ck[idx].data;
      m_known[m_top] = m_ck[idx].known;
`endif
      while (m_ck.size() > idx) void'(m_ck.pop_back());
      m_tail = int'(flush_tag_i);
    end else begin
      if (push_i && pop_i && m_cnt > 0) begin
        m_mem[m_top] = din_i; m_known[m_top] = 1;
      end else if (push_i) begin
        m_ovf = (m_cnt == D);
        m_top = (m_top + 1) % D;
        m_mem[m_top] = din_i; m_known[m_top] = 1;
        if (m_cnt < D) m_cnt++;
      end else if (pop_i && m_cnt > 0) begin
        m_top = (m_top + D - 1) % D;
        m_cnt--;
      end
      if (ckpt_req_i && can_alloc) begin
        m_ck.push_back('{m_tail, m_top, m_cnt, m_mem[m_top], m_known[m_top]});
        m_tail = (m_tail + 1) % C;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", valid_o, m_cnt > 0);
    chk("count", count_o, m_cnt);
    chk("rdy",   ckpt_rdy_o, m_ck.size() < C);
    chk("tag",   ckpt_tag_o, m_tail);
    chk("ovf",   ovf_o, m_ovf);
    if (m_known[m_top]) chk("dout", dout_o, m_mem[m_top]);
  endtask

  task automatic idle();
    rst_i = 0; push_i = 0; pop_i = 0; ckpt_req_i = 0; commit_i = 0; flush_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    idle();
  endtask

  task automatic do_reset();
    rst_i = 1; tick();
  endtask

  task automatic do_push(input logic [W-1:0] v);
    push_i = 1; din_i = v; tick();
  endtask

  task automatic do_pop();
    pop_i = 1; tick();
  endtask

  task automatic do_flush(input int t);
    flush_i = 1; flush_tag_i = 3'(t); tick();
  endtask

  initial begin
    int live_from;
    int pick;
    foreach (m_known[k]) m_known[k] = 0;
    #1;
    rst_i = 1; tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_rdy",   ckpt_rdy_o, 1);
    chk("rst_tag",   ckpt_tag_o, 0);
    chk("rst_ovf",   ovf_o, 0);

    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk("t1_dout3", dout_o, 32'h300);
    chk("t1_count3", count_o, 3);
    chk("t1_valid3", valid_o, 1);
    do_pop(); chk("t1_pop1", dout_o, 32'h200);
    do_pop(); chk("t1_pop2", dout_o, 32'h100);
    do_pop(); chk("t1_empty", valid_o, 0); chk("t1_count0", count_o, 0);

    for (int i = 1; i <= 16; i++) do_push(W'(i));
    chk("t2_ovf16", ovf_o, 0);
    do_push(32'd17);
    chk("t2_ovf17", ovf_o, 1);
    chk("t2_count", count_o, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t2_popval", dout_o, 32'(17 - i));
      do_pop();
      if (i == 0) chk("t2_ovf_clear", ovf_o, 0);
    end
    chk("t2_count_empty", count_o, 0);
    do_pop();
    chk("t2_pop_empty", count_o, 0);

    do_push(32'hA);
    push_i = 1; pop_i = 1; din_i = 32'hB; tick();
    chk("t3_dout", dout_o, 32'hB);
    chk("t3_count", count_o, 1);

    do_reset();
    do_push(32'h10); do_push(32'h20);
    chk("t4_tag", ckpt_tag_o, 0);
    ckpt_req_i = 1; tick();
    do_pop(); do_push(32'h99);
    do_flush(0);
    chk("t4_count", count_o, 2);
`ifdef RAS_TOS_REPAIR_EN
    chk("t4_dout", dout_o, 32'h20);
`else
    chk("t4_dout", dout_o, 32'h99);
`endif

    do_reset();
    do_push(32'h10); do_push(32'h20);
    ckpt_req_i = 1; tick();
    do_pop(); do_pop(); do_push(32'h99);
    do_flush(0);
    chk("t4b_count", count_o, 2);
    chk("t4b_dout", dout_o, 32'h20);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("t5_tag_seq", ckpt_tag_o, i);
      ckpt_req_i = 1; tick();
    end
    chk("t5_full", ckpt_rdy_o, 0);
    ckpt_req_i = 1; tick();
    chk("t5_drop_rdy", ckpt_rdy_o, 0);
    chk("t5_drop_tag", ckpt_tag_o, 0);
    commit_i = 1; tick();
    chk("t5_commit_rdy", ckpt_rdy_o, 1);
    chk("t5_commit_tag", ckpt_tag_o, 0);
    do_flush(3);
    chk("t5_flush_tag", ckpt_tag_o, 3);
    chk("t5_flush_rdy", ckpt_rdy_o, 1);

    do_reset();
    do_push(32'h1);
    ckpt_req_i = 1; tick();
    do_push(32'h2);
    ckpt_req_i = 1; tick();
    do_push(32'h3);
    flush_i = 1; flush_tag_i = 3'd1; commit_i = 1; push_i = 1; din_i = 32'h77; ckpt_req_i = 1; tick();
    chk("t6_count", count_o, 2);
    chk("t6_dout", dout_o, 32'h2);
    chk("t6_tag", ckpt_tag_o, 1);
    commit_i = 1; tick();
    chk("t6_head_moved", ckpt_tag_o, 1);

    for (int i = 0; i < 5; i++) begin
      push_i = 1; din_i = 32'h500 + W'(i); ckpt_req_i = 1;
      if (i == 3) rst_i = 1;
      tick();
      if (i == 3) begin
        chk("t6_rst_count", count_o, 0);
        chk("t6_rst_valid", valid_o, 0);
        chk("t6_rst_rdy", ckpt_rdy_o, 1);
        chk("t6_rst_tag", ckpt_tag_o, 0);
        chk("t6_rst_ovf", ovf_o, 0);
      end
    end

    for (int n = 0; n < 3000; n++) begin
      push_i     = ($urandom_range(0, 99) < 50);
      pop_i      = ($urandom_range(0, 99) < 40);
      din_i      = $urandom;
      ckpt_req_i = ($urandom_range(0, 99) < 35);
      commit_i   = ($urandom_range(0, 99) < 25);
      live_from  = (commit_i && m_ck.size() > 0) ? 1 : 0;
      if ($urandom_range(0, 99) < 10 && m_ck.size() > live_from) begin
        pick        = $urandom_range(live_from, m_ck.size() - 1);
        flush_i     = 1;
        flush_tag_i = 3'(m_ck[pick].tag);
      end
      if ($urandom_range(0, 499) == 0) rst_i = 1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
